// File: rtl/fifo_pop_ctrl.sv
// rtl/fifo_pop_ctrl.sv - Pop controller draining a registered FIFO into a 2-entry output buffer
module fifo_pop_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  ready_in,
    output logic                  fifo_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            state,
    output logic [7:0]            pop_count,
    output logic                  error_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                st;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  head;
    logic                  tail;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

    assign state     = st;
    assign valid_out = (occ != 2'd0);
    assign data_out  = valid_out ? mem[head] : '0;
    assign xfer      = valid_out & ready_in;
    // With one index bit the tail is head offset by occupancy; a simultaneous
    // transfer at occ=1 lands the capture in the slot the head moves onto.
    assign tail      = head ^ occ[0];

    // Counting the in-flight word against buffer space guarantees a free slot at capture.
    assign fifo_pop = !reset & enable & !fifo_empty
                    & (({1'b0, occ} + {2'b00, inflight}) < 3'd2)
                    & !(fifo_almost_empty & inflight)
                    & (st != STALL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st              <= IDLE;
            occ             <= 2'd0;
            inflight        <= 1'b0;
            head            <= 1'b0;
            pop_count       <= 8'd0;
            error_underflow <= 1'b0;
        end else begin
            inflight  <= fifo_pop;
            pop_count <= pop_count + {7'd0, fifo_pop};
            if (enable & fifo_empty & inflight & fifo_almost_empty)
                error_underflow <= 1'b1;
            if (xfer)
                head <= ~head;
            case ({inflight, xfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            case (st)
                IDLE:  if (enable & !fifo_empty) st <= DRAIN;
                DRAIN: begin
                    if (occ == 2'd2 && !ready_in)
                        st <= STALL;
                    else if ((!enable | fifo_empty) & !inflight)
                        st <= IDLE;
                end
                STALL: if (ready_in) st <= DRAIN;
                default: st <= IDLE;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (inflight)
            mem[tail] <= fifo_data;
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb/tb_fifo_pop_ctrl.sv - Randomized self-checking bench for fifo_pop_ctrl
module tb_fifo_pop_ctrl;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic [DW-1:0] fifo_data;
    logic          ready_in;
    logic          fifo_pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    state;
    logic [7:0]    pop_count;
    logic          error_underflow;

    always #5 clk = ~clk;

    fifo_pop_ctrl #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_data         (fifo_data),
        .ready_in          (ready_in),
        .fifo_pop          (fifo_pop),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .state             (state),
        .pop_count         (pop_count),
        .error_underflow   (error_underflow)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] src[$];
    logic [DW-1:0] buf_q[$];
    int            m_state    = 0;
    bit            m_inflight = 1'b0;
    int            m_count    = 0;
    bit            m_err      = 1'b0;
    logic [DW-1:0] nxt_fdata  = '0;
    bit            force_bad  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, req, $time);
    endtask

    task automatic cycle(input bit en, input bit rdy, input bit rst);
        bit            pop;
        bit            xfer;
        int            ns;
        logic [31:0]   exp_data;
        @(negedge clk);
        reset             = rst;
        enable            = en;
        ready_in          = rdy;
        fifo_empty        = force_bad ? 1'b1 : (src.size() == 0);
        fifo_almost_empty = force_bad ? 1'b1 : (src.size() == 1);
        fifo_data         = nxt_fdata;
        if (rst) begin
            buf_q.delete();
            m_state    = 0;
            m_inflight = 1'b0;
            m_count    = 0;
            m_err      = 1'b0;
        end
        pop = !rst && en && !fifo_empty && (buf_q.size() + int'(m_inflight) < 2)
              && !(fifo_almost_empty && m_inflight) && (m_state != 2);
        exp_data = (buf_q.size() != 0) ? 32'(buf_q[0]) : 32'd0;
        #1;
        check("fifo_pop",  32'(fifo_pop),        32'(pop));
        check("valid_out", 32'(valid_out),       32'(buf_q.size() != 0));
        check("data_out",  32'(data_out),        exp_data);
        check("state",     32'(state),           32'(m_state));
        check("pop_count", 32'(pop_count),       32'(m_count));
        check("err",       32'(error_underflow), 32'(m_err));
        @(posedge clk);
        if (!rst) begin
            xfer = (buf_q.size() != 0) && rdy;
            ns   = m_state;
            case (m_state)
                0: if (en && !fifo_empty) ns = 1;
                1: begin
                    if (buf_q.size() == 2 && !rdy) ns = 2;
                    else if ((!en || fifo_empty) && !m_inflight) ns = 0;
                end
                2: if (rdy) ns = 1;
                default: ns = 0;
            endcase
            m_state = ns;
            if (xfer) void'(buf_q.pop_front());
            if (m_inflight) buf_q.push_back(fifo_data);
            if (en && fifo_empty && m_inflight && fifo_almost_empty) m_err = 1'b1;
            m_count    = (m_count + int'(pop)) % 256;
            m_inflight = pop;
            if (pop) nxt_fdata = src.pop_front();
            else     nxt_fdata = DW'($urandom);
        end else begin
            nxt_fdata = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        src.delete();
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; ready_in = 1'b0;
        fifo_empty = 1'b1; fifo_almost_empty = 1'b0; fifo_data = '0;

        do_reset();
        do_reset();

        // Three preloaded words streamed with ready held high
        src = '{6'h01, 6'h02, 6'h03};
        repeat (8) cycle(1'b1, 1'b1, 1'b0);
        #2 check("three_word_count", 32'(pop_count), 32'd3);

        // Downstream blocked: two pops fill the buffer and the FSM stalls
        do_reset();
        src = '{6'h10, 6'h11, 6'h12, 6'h13};
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        #2;
        check("stall_state", 32'(state),     32'd2);
        check("stall_head",  32'(data_out),  32'h10);
        check("stall_pops",  32'(pop_count), 32'd2);
        repeat (12) cycle(1'b1, 1'b1, 1'b0);
        #2 check("stall_drained_pops", 32'(pop_count), 32'd4);

        // Last word in the FIFO: a single pop and no underflow
        do_reset();
        src = '{6'h05};
        repeat (5) cycle(1'b1, 1'b1, 1'b0);
        #2;
        check("last_word_err",  32'(error_underflow), 32'd0);
        check("last_word_pops", 32'(pop_count),       32'd1);

        // Enable drops right after one pop
        do_reset();
        src = '{6'h20, 6'h21, 6'h22, 6'h23};
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0);
        #2;
        check("disable_state", 32'(state),     32'd0);
        check("disable_pops",  32'(pop_count), 32'd1);

        // Reset while a word is buffered and another is in flight
        do_reset();
        src = '{6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h36};
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        #2 check("reset_no_stale", 32'(valid_out), 32'd0);

        // Inconsistent flags seen while a pop is in flight latch the error
        do_reset();
        src = '{6'h2a, 6'h2b};
        cycle(1'b1, 1'b1, 1'b0);
        force_bad = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        force_bad = 1'b0;
        cycle(1'b0, 1'b1, 1'b0);
        #2 check("underflow_sticky", 32'(error_underflow), 32'd1);
        do_reset();

        // Long uninterrupted drain so pop_count wraps past 255
        for (int i = 0; i < 700; i++) begin
            while (src.size() < 4) src.push_back(DW'($urandom));
            cycle(1'b1, 1'b1, 1'b0);
        end

        // Fully random traffic, occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 2) == 0 && src.size() < 6) src.push_back(DW'($urandom));
            cycle(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 200) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
